// File: rtl/mic1_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mic1_run_ctrl_if
//  Description : Board-side bundle for the MIC1 run-control unit. The master
//                modport drives the run-control inputs (mode, go button, run
//                count, breakpoints, current PC/MPC) and observes the results
//                (cpu_en, run status, breakpoint index, enable count). The
//                slave modport is the run-control unit itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mic1_run_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int MPC_WIDTH   = 9,
    parameter int COUNT_WIDTH = 16,
    parameter int NUM_BP      = 2
);
    logic [1:0]                 mode;
    logic                       go_btn;
    logic [COUNT_WIDTH-1:0]     run_count;
    logic [NUM_BP-1:0]          bp_enable;
    logic [NUM_BP*PC_WIDTH-1:0] bp_addr;
    logic [PC_WIDTH-1:0]        pc_in;
    logic [MPC_WIDTH-1:0]       mpc_in;
    logic                       cpu_en;
    logic                       running;
    logic                       halted_bp;
    logic [2:0]                 bp_idx;
    logic [31:0]                cycle_count;

    modport master (
        output mode, go_btn, run_count, bp_enable, bp_addr, pc_in, mpc_in,
        input  cpu_en, running, halted_bp, bp_idx, cycle_count
    );

    modport slave (
        input  mode, go_btn, run_count, bp_enable, bp_addr, pc_in, mpc_in,
        output cpu_en, running, halted_bp, bp_idx, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mic1_run_ctrl
//  Description : Run-control unit for the MIC1 core. Produces a per-cycle
//                clock enable (cpu_en) with halt / single-step / run-N /
//                free-run modes, a debounced go button and PC breakpoints
//                that are checked only at the instruction-fetch microstep.
//  Ports       : clock, reset (async, active-high)
//                bus.mode/go_btn/run_count     - run request
//                bus.bp_enable/bp_addr         - breakpoint comparators
//                bus.pc_in/mpc_in              - core PC and MPC
//                bus.cpu_en                    - combinational core enable
//                bus.running/halted_bp/bp_idx  - status
//                bus.cycle_count               - total enabled cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module mic1_run_ctrl #(
    parameter int                   PC_WIDTH        = 32,
    parameter int                   MPC_WIDTH       = 9,
    parameter int                   COUNT_WIDTH     = 16,
    parameter int                   NUM_BP          = 2,
    parameter logic [MPC_WIDTH-1:0] FETCH_MPC       = 9'h000,
    parameter int                   DEBOUNCE_CYCLES = 50000
) (
    input  wire logic       clock,
    input  wire logic       reset,
    mic1_run_ctrl_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_RUN_N    = 3'd2,
        ST_RUN_FREE = 3'd3,
        ST_BREAK    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    state_t                 resume_q, resume_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   skip_q, skip_d;
    logic [2:0]             bp_idx_q, bp_idx_d;
    logic [31:0]            cycle_count_q, cycle_count_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   db_q, db_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   go_q, go_d;

    logic                   pc_match;
    logic [2:0]             hit_idx;
    logic                   hit;
    logic                   cpu_en;

    // Debouncer: the accepted level only flips after DEBOUNCE_CYCLES
    // consecutive synchronised samples that disagree with it; any agreeing
    // sample restarts the count. go fires on the accepted rising edge.
    always_comb begin
        sync1_d  = bus.go_btn;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        go_d = db_d & ~db_q;
    end

    // Scan from the top so the lowest matching index is the one left behind.
    always_comb begin
        pc_match = 1'b0;
        hit_idx  = 3'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bus.bp_enable[i] && (bus.pc_in == bus.bp_addr[i*PC_WIDTH +: PC_WIDTH])) begin
                pc_match = 1'b1;
                hit_idx  = 3'(i);
            end
        end
        hit = pc_match && (bus.mpc_in == FETCH_MPC);
    end

    // Enable is decoded from state so a reset mid-run kills it at once.
    // skip lets the first cycle after a resume step over the breakpoint.
    always_comb begin
        case (state_q)
            ST_STEP:              cpu_en = 1'b1;
            ST_RUN_N, ST_RUN_FREE: cpu_en = !(hit && !skip_q);
            default:              cpu_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        remaining_d   = remaining_q;
        skip_d        = skip_q;
        bp_idx_d      = bp_idx_q;
        cycle_count_d = cycle_count_q + 32'(cpu_en);
        case (state_q)
            ST_IDLE: begin
                skip_d = 1'b0;
                if (go_q) begin
                    case (bus.mode)
                        2'b01: state_d = ST_STEP;
                        2'b10: begin
                            if (bus.run_count != '0) begin
                                remaining_d = bus.run_count;
                                state_d     = ST_RUN_N;
                            end
                        end
                        2'b11: state_d = ST_RUN_FREE;
                        default: ;
                    endcase
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_RUN_N, ST_RUN_FREE: begin
                if (cpu_en) begin
                    skip_d = 1'b0;
                end
                if ((state_q == ST_RUN_N) && cpu_en) begin
                    remaining_d = remaining_q - 1'b1;
                end
                // Break outranks go; in every branch below cpu_en is 1.
                if (hit && !skip_q) begin
                    state_d  = ST_BREAK;
                    bp_idx_d = hit_idx;
                    resume_d = state_q;
                end else if (go_q || (bus.mode == 2'b00)) begin
                    state_d = ST_IDLE;
                end else if ((state_q == ST_RUN_N) && (remaining_q == COUNT_WIDTH'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (go_q) begin
                    state_d = resume_q;
                    skip_d  = 1'b1;
                end else if (bus.mode == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            resume_q      <= ST_IDLE;
            remaining_q   <= '0;
            skip_q        <= 1'b0;
            bp_idx_q      <= 3'd0;
            cycle_count_q <= 32'd0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_q          <= 1'b0;
            db_cnt_q      <= '0;
            go_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            remaining_q   <= remaining_d;
            skip_q        <= skip_d;
            bp_idx_q      <= bp_idx_d;
            cycle_count_q <= cycle_count_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_q          <= db_d;
            db_cnt_q      <= db_cnt_d;
            go_q          <= go_d;
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.running     = (state_q == ST_STEP) || (state_q == ST_RUN_N) ||
                             (state_q == ST_RUN_FREE);
    assign bus.halted_bp   = (state_q == ST_BREAK);
    assign bus.bp_idx      = bp_idx_q;
    assign bus.cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mic1_run_ctrl
//  Description : Self-checking bench for mic1_run_ctrl (debounce of 4 cycles,
//                two breakpoints, fetch MPC 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mic1_run_ctrl;

    localparam int         PC_W  = 32;
    localparam int         MPC_W = 9;
    localparam int         CNT_W = 16;
    localparam int         NBP   = 2;
    localparam int         DB    = 4;
    localparam logic [8:0] FETCH = 9'h000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mic1_run_ctrl_if #(.PC_WIDTH(PC_W), .MPC_WIDTH(MPC_W), .COUNT_WIDTH(CNT_W), .NUM_BP(NBP)) bus();

    mic1_run_ctrl #(
        .PC_WIDTH(PC_W), .MPC_WIDTH(MPC_W), .COUNT_WIDTH(CNT_W), .NUM_BP(NBP),
        .FETCH_MPC(FETCH), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int run_cnt = 0;
    int last_en_cyc = 0;
    int press_cyc = 0;
    int model_total = 0;

    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (bus.cpu_en === 1'b1) begin
            en_cnt++;
            last_en_cyc = cyc;
        end
        if (bus.running === 1'b1) run_cnt++;
    end

    typedef struct {
        logic [1:0]  en;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] pc;
        logic [8:0]  mpc;
        logic        exp_en;
        logic [2:0]  exp_idx;
    } vec_t;
    vec_t vt[7];

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Let the debouncer settle low, then hold the button for len cycles.
    task automatic press(input int len);
        bus.go_btn = 1'b0;
        repeat (DB + 4) next();
        bus.go_btn = 1'b1;
        press_cyc = cyc;
        repeat (len) next();
        bus.go_btn = 1'b0;
    endtask

    task automatic wait_en(input string name, input int bound);
        int n = 0;
        while (bus.cpu_en !== 1'b1 && n < bound) begin
            next();
            n++;
        end
        if (bus.cpu_en !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: cpu_en not seen within %0d cycles", name, bound);
        end
    endtask

    function automatic int first_hit(logic [1:0] en, logic [63:0] addrs, logic [31:0] pc, logic [8:0] mpc);
        if (mpc != FETCH) return -1;
        for (int i = 0; i < NBP; i++)
            if (en[i] && addrs[i*32 +: 32] == pc) return i;
        return -1;
    endfunction

    task automatic start_free();
        bus.mode   = 2'b11;
        bus.mpc_in = 9'h001;
        press(5);
        wait_en("start_free", 12);
    endtask

    initial begin
        int e0, r0, k, n_req, issued, guard, idx;
        logic exp_en;

        vt[0] = '{2'b01, 32'h10, 32'h20, 32'h10, 9'h000, 1'b0, 3'd0};
        vt[1] = '{2'b11, 32'h20, 32'h20, 32'h20, 9'h000, 1'b0, 3'd0};
        vt[2] = '{2'b11, 32'h20, 32'h20, 32'h20, 9'h005, 1'b1, 3'd0};
        vt[3] = '{2'b10, 32'h30, 32'h30, 32'h30, 9'h000, 1'b0, 3'd1};
        vt[4] = '{2'b00, 32'h30, 32'h30, 32'h30, 9'h000, 1'b1, 3'd0};
        vt[5] = '{2'b10, 32'h40, 32'h44, 32'h40, 9'h000, 1'b1, 3'd0};
        vt[6] = '{2'b11, 32'h50, 32'h60, 32'h60, 9'h000, 1'b0, 3'd1};

        bus.mode = 2'b00; bus.go_btn = 1'b0; bus.run_count = '0;
        bus.bp_enable = '0; bus.bp_addr = '0; bus.pc_in = '0; bus.mpc_in = 9'h001;
        repeat (3) next();
        chk("reset_cpu_en", 32'(bus.cpu_en), 0);
        chk("reset_running", 32'(bus.running), 0);
        chk("reset_halted", 32'(bus.halted_bp), 0);
        chk("reset_bp_idx", 32'(bus.bp_idx), 0);
        chk("reset_cycle_count", bus.cycle_count, 0);
        reset = 1'b0;
        next();

        // Glitch shorter than the debounce window, and a press in halt mode.
        bus.mode = 2'b01;
        e0 = en_cnt;
        press(3);
        repeat (15) next();
        chk("glitch_no_enable", 32'(en_cnt - e0), 0);
        bus.mode = 2'b00;
        press(10);
        repeat (10) next();
        chk("halt_mode_no_enable", 32'(en_cnt - e0), 0);

        // Single-step: three presses, first one held long with latency check.
        bus.mode = 2'b01;
        r0 = run_cnt;
        press(10);
        repeat (10) next();
        chk("step_latency", 32'(last_en_cyc - press_cyc), 32'(DB + 3));
        press(5);
        repeat (10) next();
        press(5);
        repeat (10) next();
        chk("step_enables", 32'(en_cnt - e0), 3);
        chk("step_running_cycles", 32'(run_cnt - r0), 3);
        model_total = 3;
        chk("step_cycle_count", bus.cycle_count, 32'(model_total));

        // Run-N for 5 and for 0.
        bus.mode = 2'b10; bus.run_count = 16'd5;
        press(5);
        wait_en("run5", 12);
        k = 0;
        while (bus.cpu_en === 1'b1 && k < 20) begin
            k++;
            next();
        end
        chk("run5_len", 32'(k), 5);
        chk("run5_idle", 32'(bus.running), 0);
        model_total += 5;
        chk("run5_cycle_count", bus.cycle_count, 32'(model_total));
        bus.run_count = 16'd0;
        e0 = en_cnt;
        press(5);
        repeat (12) next();
        chk("run0_no_enable", 32'(en_cnt - e0), 0);
        chk("run0_idle", 32'(bus.running), 0);

        // Randomised run-N with random breakpoints and PC stream.
        for (int t = 0; t < 10; t++) begin
            n_req = $urandom_range(1, 12);
            issued = 0;
            guard = 0;
            bus.bp_enable = 2'($urandom);
            bus.bp_addr = {32'h10 + 32'($urandom_range(0, 3)), 32'h10 + 32'($urandom_range(0, 3))};
            bus.mpc_in = 9'h001;
            bus.mode = 2'b10;
            bus.run_count = 16'(n_req);
            press(5);
            wait_en("rnd_start", 12);
            issued = 1;
            while (issued < n_req && guard < 400) begin
                guard++;
                next();
                bus.pc_in = 32'h10 + 32'($urandom_range(0, 3));
                bus.mpc_in = ($urandom_range(0, 1) == 0) ? FETCH : 9'h001;
                #1;
                idx = first_hit(bus.bp_enable, bus.bp_addr, bus.pc_in, bus.mpc_in);
                exp_en = (idx < 0);
                chk("rnd_cpu_en", 32'(bus.cpu_en), 32'(exp_en));
                if (exp_en) begin
                    issued++;
                end else begin
                    next();
                    chk("rnd_halted", 32'(bus.halted_bp), 1);
                    chk("rnd_bp_idx", 32'(bus.bp_idx), 32'(idx));
                    press(5);
                    wait_en("rnd_resume", 12);
                    chk("rnd_resume_running", 32'(bus.running), 1);
                    issued++;
                end
            end
            next();
            chk("rnd_done_idle", 32'(bus.running), 0);
            model_total += n_req;
            chk("rnd_cycle_count", bus.cycle_count, 32'(model_total));
        end

        // Breakpoint vectors in free-run.
        bus.mpc_in = 9'h001;
        start_free();
        for (int v = 0; v < 7; v++) begin
            next();
            bus.bp_enable = vt[v].en;
            bus.bp_addr = {vt[v].a1, vt[v].a0};
            bus.pc_in = vt[v].pc;
            bus.mpc_in = vt[v].mpc;
            #1;
            chk($sformatf("vec%0d_cpu_en", v), 32'(bus.cpu_en), 32'(vt[v].exp_en));
            next();
            bus.mpc_in = 9'h001;
            chk($sformatf("vec%0d_halted", v), 32'(bus.halted_bp), 32'(!vt[v].exp_en));
            if (!vt[v].exp_en) begin
                chk($sformatf("vec%0d_bp_idx", v), 32'(bus.bp_idx), 32'(vt[v].exp_idx));
                bus.mode = 2'b00;
                next();
                chk($sformatf("vec%0d_break_to_idle", v), 32'(bus.halted_bp), 0);
                start_free();
            end
        end

        // Resume past a breakpoint, then mode 00 aborts free-run.
        next();
        bus.bp_enable = 2'b01;
        bus.bp_addr = {32'h0, 32'h10};
        bus.pc_in = 32'h10;
        bus.mpc_in = FETCH;
        #1;
        chk("resume_break_en", 32'(bus.cpu_en), 0);
        next();
        chk("resume_halted", 32'(bus.halted_bp), 1);
        chk("resume_idx", 32'(bus.bp_idx), 0);
        press(5);
        wait_en("resume_skip", 12);
        chk("resume_running", 32'(bus.running), 1);
        next();
        bus.pc_in = 32'h14;
        #1;
        chk("resume_continue_en", 32'(bus.cpu_en), 1);
        chk("resume_continue_halted", 32'(bus.halted_bp), 0);
        next();
        bus.mode = 2'b00;
        next();
        chk("mode00_abort", 32'(bus.running), 0);

        // Reset in the middle of a 100-cycle run.
        bus.bp_enable = '0;
        bus.mpc_in = 9'h001;
        bus.mode = 2'b10;
        bus.run_count = 16'd100;
        press(5);
        wait_en("run100", 12);
        repeat (39) next();
        chk("run100_live", 32'(bus.cpu_en), 1);
        reset = 1'b1;
        #1;
        chk("midrun_reset_en", 32'(bus.cpu_en), 0);
        chk("midrun_reset_cc", bus.cycle_count, 0);
        chk("midrun_reset_running", 32'(bus.running), 0);
        next();
        reset = 1'b0;
        repeat (3) next();
        chk("post_reset_idle", 32'(bus.running), 0);
        chk("post_reset_en", 32'(bus.cpu_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
